mont_expo_param: RTL and testbench
==================================

Name: mont_expo_param

Overview:
- Parametrised modular exponentiator z = base^expo mod modulus; successor to the fixed 192-bit Montgomery exponentiator.
- Adds:
  - run-time modulus input;
  - precomputed R² input;
  - WIDTH parameter;
  - busy/err outputs;
  - exponent leading-zero skip.
- Left-to-right square-and-multiply over a radix-2 bit-serial Montgomery multiplier.
- Sits under the crypto top level as the RSA/modexp engine.

Parameters:
- WIDTH, 192, operand/modulus width in bits (≥ 4). R = 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle request; sampled only when busy=0
- base  input  WIDTH  base, must be < modulus
- expo  input  WIDTH  exponent
- modulus  input  WIDTH  odd modulus n
- r2  input  WIDTH  R² mod n, supplied by software
- z  output  WIDTH  result, held until next accepted start
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse, result valid
- err  output  1  set with done when modulus is even; cleared on next accepted start

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: z=0, busy=0, done=0, err=0, FSM=IDLE. Reset mid-operation aborts with no done pulse.
- Capture: on start & ~busy, all inputs are registered; later input changes have no effect. start while busy is ignored.
- MM sub-op computes MM(a,b) = a·b·R⁻¹ mod n.
  - Each iteration i = 0..WIDTH-1: t += a[i]·b; if t odd, t += n; t >>= 1.
  - Final step: if t ≥ n, t -= n.
  - Internal t is WIDTH+2 bits.
  - Latency L = WIDTH+2 cycles: 1 load + WIDTH iterations + 1 correction.
- FSM states and transitions:
  - IDLE → CHK.
  - CHK (1 cycle):
    - n[0]=0: DONE with err=1, z=0.
    - expo=0: DONE with z = (n==1 ? 0 : 1).
    - Otherwise: bit index k = position of the MSB of expo, then TOX.
  - TOX: xm = MM(base, r2).
  - TOA: acc = MM(1, r2) = R mod n.
  - SQR: acc = MM(acc, acc).
    - If expo[k]=1: MUL.
    - Otherwise: k==0 → FROM, else k--, SQR.
  - MUL: acc = MM(acc, xm). Then k==0 → FROM, else k--, SQR.
  - FROM: z = MM(acc, 1).
  - DONE (1 cycle): done=1, busy=0 next, → IDLE.
- Latency: done is asserted exactly (4 + k_msb + popcount(expo))·L + 2 cycles after the start-sampling edge.
  - The expo=0 and even-modulus paths take 2 cycles.
- Boundary cases:
  - base ≥ n, or r2 ≠ R² mod n: result undefined, no hang; done still occurs.
  - n=1: z=0.

Optional Feature:
- Macro: MONT_EXPO_CT_EN.
- Defined (constant-time ladder):
  - No leading-zero skip; k starts at WIDTH-1.
  - MUL executes for every bit; the product is discarded when the bit is 0.
  - Latency is fixed at (3 + 2·WIDTH)·L + 2 for all non-error inputs, including expo=0.
- Undefined: behaviour as above.

Decomposition:
- Shared package mont_pkg: FSM state encoding constants and the MM latency constant expression.
- One sub-module, mont_mul_param:
  - Parameter WIDTH.
  - Ports: clk, reset, start, a, b, n, z, done.
  - Instantiated once; the top-level FSM muxes the operands.

Test Plan:
- WIDTH=8, n=187, r2=86, base=5, expo=3 → z=125, err=0; done at (4+1+2)·10+2 = 72 cycles; busy high throughout.
- WIDTH=8, n=187, r2=86, base=2, expo=10 → z=89; expo=0 → z=1 after 2 cycles; n=1, expo=0 → z=0.
- WIDTH=8, n=16 (even) → done after 2 cycles, err=1, z=0. A following valid start clears err.
- WIDTH=192:
  - base=0x6543210fedcba9876543210fedcba9876543210fedcba987
  - expo=0xfedcba9876543210fedcba9876543210fedcba9876543210
  - odd n, with r2 from the software model
  → z matches pow(base, expo, n) in the model.
- Reset mid-SQR, then start pulsed while busy:
  - reset → z=0, busy=0, no done.
  - Start while busy is ignored, with no change to the captured operands.
- MONT_EXPO_CT_EN, WIDTH=8: expo=1 and expo=0xFF both finish in 192 cycles, with correct z.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared definitions for the parametrised Montgomery exponentiator:
// top-level FSM encoding, multiplier phase encoding and MM latency.
package mont_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_TOX, S_TOA, S_SQR, S_MUL, S_FROM, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MM_IDLE, MM_RUN, MM_CORR
  } mm_phase_t;

  // Cycles per MM: one load, one per operand bit, one final correction.
  function automatic int mm_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/mont_mul_param.sv
// Radix-2 bit-serial Montgomery multiplier: z = a*b*2^-WIDTH mod n.
// start is sampled only while idle; done is high for the single correction
// cycle and z is valid alongside it, so the caller can consume the result
// on the same edge that returns this unit to idle.
module mont_mul_param
  import mont_pkg::*;
#(
  parameter int WIDTH = 192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] z,
  output logic             done
);

  localparam int ITERS = mm_latency(WIDTH) - 2;
  localparam int CW    = $clog2(ITERS);
  localparam int TW    = WIDTH + 2;

  mm_phase_t        phase;
  logic [WIDTH-1:0] a_sh, b_r, n_r;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    t, t_add, t_odd, t_next, b_ext, n_ext;

  // One reduction step. t stays below 2^(WIDTH+1) even for out-of-range
  // operands, so t + b + n never overflows WIDTH+2 bits.
  always_comb begin
    b_ext  = {2'b00, b_r};
    n_ext  = {2'b00, n_r};
    t_add  = t + (a_sh[0] ? b_ext : '0);
    t_odd  = t_add[0] ? t_add + n_ext : t_add;
    t_next = t_odd >> 1;
    z      = (t >= n_ext) ? WIDTH'(t - n_ext) : WIDTH'(t);
    done   = (phase == MM_CORR);
  end

  // Load operands, iterate once per bit of a, then hold for the correction.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= MM_IDLE;
      cnt   <= '0;
      t     <= '0;
      a_sh  <= '0;
      b_r   <= '0;
      n_r   <= '0;
    end else begin
      case (phase)
        MM_IDLE: if (start) begin
          a_sh  <= a;
          b_r   <= b;
          n_r   <= n;
          t     <= '0;
          cnt   <= '0;
          phase <= MM_RUN;
        end
        MM_RUN: begin
          t    <= t_next;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) phase <= MM_CORR;
        end
        MM_CORR: phase <= MM_IDLE;
        default: phase <= MM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mont_expo_param.sv
// Parametrised modular exponentiator z = base^expo mod modulus using
// left-to-right square-and-multiply over one shared Montgomery multiplier.
// Optional build macro MONT_EXPO_CT_EN selects a constant-time ladder:
// every exponent bit is squared and multiplied, products for zero bits are
// discarded, and the exponent leading-zero skip is disabled.
module mont_expo_param
  import mont_pkg::*;
#(
  parameter int WIDTH = 192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] expo,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] z,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, nxt;
  logic [WIDTH-1:0] base_r, expo_r, n_r, r2_r;
  logic [WIDTH-1:0] xm, acc;
  logic [WIDTH-1:0] mm_a, mm_b, mm_z;
  logic [KW-1:0]    k;
  logic             mm_start, mm_done, accept, cur_bit;

  assign accept  = start & ~busy;
  assign cur_bit = expo_r[k];

`ifndef MONT_EXPO_CT_EN
  logic [KW-1:0] msb;

  // Index of the most significant set exponent bit (leading-zero skip).
  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++)
      if (expo_r[i]) msb = KW'(i);
  end
`endif

  mont_mul_param #(.WIDTH(WIDTH)) u_mm (
    .clk   (clk),
    .reset (reset),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .n     (n_r),
    .z     (mm_z),
    .done  (mm_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state logic; MM states advance only on the multiplier's done.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (accept) nxt = S_CHK;
      S_CHK: begin
        if (!n_r[0])              nxt = S_DONE;
`ifndef MONT_EXPO_CT_EN
        else if (expo_r == '0)    nxt = S_DONE;
`endif
        else                      nxt = S_TOX;
      end
      S_TOX:  if (mm_done) nxt = S_TOA;
      S_TOA:  if (mm_done) nxt = S_SQR;
      S_SQR: if (mm_done) begin
`ifdef MONT_EXPO_CT_EN
        nxt = S_MUL;
`else
        if (cur_bit)      nxt = S_MUL;
        else if (k == '0) nxt = S_FROM;
        else              nxt = S_SQR;
`endif
      end
      S_MUL:  if (mm_done) nxt = (k == '0) ? S_FROM : S_SQR;
      S_FROM: if (mm_done) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Multiplier operand selection for the current sub-operation.
  always_comb begin
    mm_a = acc;
    mm_b = acc;
    case (state)
      S_TOX:  begin mm_a = base_r; mm_b = r2_r; end
      S_TOA:  begin mm_a = ONE;    mm_b = r2_r; end
      S_MUL:  begin mm_a = acc;    mm_b = xm;   end
      S_FROM: begin mm_a = acc;    mm_b = ONE;  end
      default: ;
    endcase
  end

  // Operand capture, accumulator/bit-index updates and result outputs.
  // mm_start pulses in the first cycle of every MM state so each
  // sub-operation occupies exactly mm_latency(WIDTH) cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r   <= '0;
      expo_r   <= '0;
      n_r      <= '0;
      r2_r     <= '0;
      xm       <= '0;
      acc      <= '0;
      k        <= '0;
      mm_start <= 1'b0;
      z        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      mm_start <= (nxt inside {S_TOX, S_TOA, S_SQR, S_MUL, S_FROM}) &&
                  (state == S_CHK || mm_done);
      case (state)
        S_IDLE: if (accept) begin
          base_r <= base;
          expo_r <= expo;
          n_r    <= modulus;
          r2_r   <= r2;
          busy   <= 1'b1;
          err    <= 1'b0;
        end
        S_CHK: begin
          if (!n_r[0]) acc <= '0;
`ifdef MONT_EXPO_CT_EN
          k <= KW'(WIDTH - 1);
`else
          else if (expo_r == '0) acc <= (n_r == ONE) ? '0 : ONE;
          k <= msb;
`endif
        end
        S_TOX: if (mm_done) xm  <= mm_z;
        S_TOA: if (mm_done) acc <= mm_z;
        S_SQR: if (mm_done) begin
          acc <= mm_z;
`ifndef MONT_EXPO_CT_EN
          if (!cur_bit && k != '0) k <= k - 1'b1;
`endif
        end
        S_MUL: if (mm_done) begin
`ifdef MONT_EXPO_CT_EN
          if (cur_bit) acc <= mm_z;
`else
          acc <= mm_z;
`endif
          if (k != '0) k <= k - 1'b1;
        end
        S_FROM: if (mm_done) acc <= mm_z;
        S_DONE: begin
          z    <= acc;
          done <= 1'b1;
          busy <= 1'b0;
          err  <= ~n_r[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_expo_param.sv
// Directed bench for mont_expo_param: 8-bit vectors with hand-computed
// results plus one 192-bit vector checked against a plain modexp model.
module tb_mont_expo_param;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] base8 = '0, expo8 = '0, mod8 = '0, r2_8 = '0, z8;
  logic       busy8, done8, err8;

  logic         start192 = 1'b0;
  logic [191:0] base192 = '0, expo192 = '0, mod192 = '0, r2_192 = '0, z192;
  logic         busy192, done192, err192;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mont_expo_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .base(base8), .expo(expo8),
    .modulus(mod8), .r2(r2_8), .z(z8), .busy(busy8), .done(done8), .err(err8)
  );

  mont_expo_param #(.WIDTH(192)) dut192 (
    .clk(clk), .reset(reset), .start(start192), .base(base192), .expo(expo192),
    .modulus(mod192), .r2(r2_192), .z(z192), .busy(busy192), .done(done192),
    .err(err192)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Expected 8-bit latency (L = 10).
  function automatic int lat8(input int k, input int pop, input bit trivial);
    int v;
    v = trivial ? 2 : (4 + k + pop) * 10 + 2;
`ifdef MONT_EXPO_CT_EN
    v = 19 * 10 + 2;
`endif
    return v;
  endfunction

  function automatic logic [191:0] mulmod(input logic [191:0] a, b, n);
    logic [383:0] p, r;
    p = {192'b0, a} * {192'b0, b};
    r = p % {192'b0, n};
    return r[191:0];
  endfunction

  function automatic logic [191:0] modexp(input logic [191:0] b, e, n);
    logic [191:0] r;
    r = mulmod(192'd1, 192'd1, n);
    for (int i = 191; i >= 0; i--) begin
      r = mulmod(r, r, n);
      if (e[i]) r = mulmod(r, b, n);
    end
    return r;
  endfunction

  // One 8-bit operation; start sampled on the posedge before cyc=0.
  // With disturb set, junk operands and a start pulse arrive mid-run.
  task automatic run8(input logic [7:0] b, e, n, r, input bit disturb,
                      output int cyc, output bit busy_ok, output logic err0);
    @(negedge clk);
    base8 = b; expo8 = e; mod8 = n; r2_8 = r; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; cyc = 0; busy_ok = 1'b1; err0 = err8;
    while (!done8 && cyc < 1000) begin
      if (!busy8) busy_ok = 1'b0;
      if (disturb && cyc == 5) begin
        base8 = 8'hAA; expo8 = 8'h55; mod8 = 8'h10; r2_8 = 8'h33; start8 = 1'b1;
      end else start8 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
  endtask

  initial begin
    int cyc, seen;
    bit busy_ok;
    logic err0;
    logic [384:0] big;
    logic [191:0] exp192;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_z", z8, 0);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_err", err8, 0);

    // 5^3 mod 187 = 125
    run8(8'd5, 8'd3, 8'd187, 8'd86, 1'b0, cyc, busy_ok, err0);
    check("p3_z", z8, 125);
    check("p3_err", err8, 0);
    check("p3_lat", cyc, lat8(1, 2, 0));
    check("p3_busy", busy_ok, 1);
    base8 = 8'd9; expo8 = 8'd7; mod8 = 8'd101; r2_8 = 8'd1;
    repeat (3) @(negedge clk);
    check("hold_z", z8, 125);
    check("hold_done", done8, 0);

    // 2^10 mod 187 = 89, with an ignored start and operand change mid-run
    run8(8'd2, 8'd10, 8'd187, 8'd86, 1'b1, cyc, busy_ok, err0);
    check("p10_z", z8, 89);
    check("p10_lat", cyc, lat8(3, 2, 0));
    check("p10_busy", busy_ok, 1);

    // expo = 0
    run8(8'd5, 8'd0, 8'd187, 8'd86, 1'b0, cyc, busy_ok, err0);
    check("e0_z", z8, 1);
    check("e0_lat", cyc, lat8(0, 0, 1));

    // n = 1, expo = 0
    run8(8'd0, 8'd0, 8'd1, 8'd0, 1'b0, cyc, busy_ok, err0);
    check("n1_z", z8, 0);
    check("n1_lat", cyc, lat8(0, 0, 1));

    // even modulus
    run8(8'd5, 8'd3, 8'd16, 8'd0, 1'b0, cyc, busy_ok, err0);
    check("even_err", err8, 1);
    check("even_z", z8, 0);
    check("even_lat", cyc, 2);

    // valid start clears err
    run8(8'd5, 8'd3, 8'd187, 8'd86, 1'b0, cyc, busy_ok, err0);
    check("clr_err_early", err0, 0);
    check("clr_err", err8, 0);
    check("clr_z", z8, 125);

    // reset in the middle of the first SQR
    @(negedge clk);
    base8 = 8'd5; expo8 = 8'd3; mod8 = 8'd187; r2_8 = 8'd86; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (25) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_z", z8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("rst_no_done", seen, 0);

    // 5^1 = 5, 5^255 mod 187 = 177 (fixed 192 cycles in constant-time build)
    run8(8'd5, 8'd1, 8'd187, 8'd86, 1'b0, cyc, busy_ok, err0);
    check("e1_z", z8, 5);
    check("e1_lat", cyc, lat8(0, 1, 0));
    run8(8'd5, 8'hFF, 8'd187, 8'd86, 1'b0, cyc, busy_ok, err0);
    check("eff_z", z8, 177);
    check("eff_lat", cyc, lat8(7, 8, 0));

`ifndef MONT_EXPO_CT_EN
    // 192-bit vector over the P-192 prime
    mod192  = 192'hffffffffffffffff_fffffffffffffffe_ffffffffffffffff;
    base192 = 192'h6543210fedcba987_6543210fedcba987_6543210fedcba987;
    expo192 = 192'hfedcba9876543210_fedcba9876543210_fedcba9876543210;
    big = 385'b1 << 384;
    big = big % {193'b0, mod192};
    r2_192 = big[191:0];
    exp192 = modexp(base192, expo192, mod192);
    @(negedge clk);
    start192 = 1'b1;
    @(negedge clk);
    start192 = 1'b0;
    cyc = 0;
    while (!done192 && cyc < 90000) begin
      @(negedge clk);
      cyc++;
    end
    check("w192_z", z192, exp192);
    check("w192_lat", cyc, (4 + 191 + $countones(expo192)) * 194 + 2);
    check("w192_err", err192, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
